// File: rtl/seq_divider.sv
//-----------------------------------------------------------------------------
// Module   : seq_divider
// Purpose  : Sequential unsigned restoring divider. Accepts a dividend/divisor
//            pair on a start pulse, produces one quotient bit per clock and
//            returns quotient and remainder with a one-cycle done pulse.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH          operand width in bits (2..16), default 4
//
// Ports
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   i_start        in   1      request, sampled only while idle
//   i_dividend     in   WIDTH  unsigned numerator, sampled with i_start
//   i_divisor      in   WIDTH  unsigned denominator, sampled with i_start
//   o_busy         out  1      high while a division is in progress
//   o_done         out  1      one-cycle completion pulse
//   o_quotient     out  WIDTH  result, held until the next completion
//   o_remainder    out  WIDTH  result, held until the next completion
//   o_div_by_zero  out  1      error flag, updated at each completion
//
// Configuration macro
//   DIV_ZERO_CHECK_EN  when defined, a zero divisor completes immediately
//                      with quotient = all ones, remainder = dividend and
//                      o_div_by_zero = 1. When undefined, o_div_by_zero is
//                      tied low and a zero divisor runs the normal algorithm.
//-----------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  // Counter just wide enough to index steps 0..WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_ONE       = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Datapath registers
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quo_work;
  logic [WIDTH:0]   r_prem;
  logic [CW-1:0]    r_count;

  // Output registers
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  // Control decoded from the FSM
  logic w_load;
  logic w_step;
  logic w_finish;

  // One restoring step
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_trial_ok;
  logic [WIDTH:0]   w_next_prem;
  logic [WIDTH-1:0] w_next_quo;

`ifdef DIV_ZERO_CHECK_EN
  logic w_zero_hit;
  logic r_div_by_zero;
`endif

  //---------------------------------------------------------------------------
  // Restoring step. The shifted partial remainder keeps one guard bit above
  // the WIDTH+1-bit register so the subtraction borrow lands in the MSB of
  // w_diff and serves directly as the sign of the trial.
  //---------------------------------------------------------------------------
  always_comb begin
    w_shift     = {r_prem, r_quo_work[WIDTH-1]};
    w_diff      = w_shift - {2'b00, r_divisor};
    w_trial_ok  = ~w_diff[WIDTH+1];
    w_next_prem = w_trial_ok ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    w_next_quo  = {r_quo_work[WIDTH-2:0], w_trial_ok};
  end

  //---------------------------------------------------------------------------
  // FSM state register
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //---------------------------------------------------------------------------
  // FSM next-state and control decode
  //---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    w_zero_hit   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
`ifdef DIV_ZERO_CHECK_EN
          // A zero divisor is answered immediately and never enters RUN.
          if (i_divisor == '0) begin
            w_zero_hit = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_next_state = S_RUN;
          end
`else
          w_load       = 1'b1;
          w_next_state = S_RUN;
`endif
        end
      end
      S_RUN: begin
        // i_start is deliberately not looked at here.
        w_step = 1'b1;
        if (r_count == c_LAST_STEP) begin
          w_finish     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // Working registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divisor  <= '0;
      r_quo_work <= '0;
      r_prem     <= '0;
      r_count    <= '0;
    end else if (w_load) begin
      r_divisor  <= i_divisor;
      r_quo_work <= i_dividend;
      r_prem     <= '0;
      r_count    <= '0;
    end else if (w_step) begin
      r_prem     <= w_next_prem;
      r_quo_work <= w_next_quo;
      r_count    <= r_count + c_ONE;
    end
  end

  //---------------------------------------------------------------------------
  // Result registers. The final step's results are captured straight from
  // the step logic so they are valid in the done cycle itself.
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
`ifdef DIV_ZERO_CHECK_EN
      r_done <= w_finish | w_zero_hit;
`else
      r_done <= w_finish;
`endif
      if (w_finish) begin
        r_quotient  <= w_next_quo;
        r_remainder <= w_next_prem[WIDTH-1:0];
      end
`ifdef DIV_ZERO_CHECK_EN
      else if (w_zero_hit) begin
        r_quotient  <= '1;
        r_remainder <= i_dividend;
      end
`endif
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_by_zero <= 1'b0;
    end else if (w_finish) begin
      r_div_by_zero <= 1'b0;
    end else if (w_zero_hit) begin
      r_div_by_zero <= 1'b1;
    end
  end

  assign o_div_by_zero = r_div_by_zero;
`else
  assign o_div_by_zero = 1'b0;
`endif

  assign o_busy      = (r_state == S_RUN);
  assign o_done      = r_done;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//-----------------------------------------------------------------------------
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider (WIDTH = 4). Expected
//            results and completion cycles are queued when a request is
//            driven and compared when o_done is seen.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  // Reference model of a division result and its completion cycle.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int now);
    exp_t m;
    if (b == 0) begin
      m.q   = {WIDTH{1'b1}};
      m.r   = a;
      m.dz  = ZCHK;
      m.due = ZCHK ? now + 1 : now + 1 + WIDTH;
    end else begin
      m.q   = a / b;
      m.r   = a % b;
      m.dz  = 1'b0;
      m.due = now + 1 + WIDTH;
    end
    return m;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_done === 1'b1) begin
      n_done++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done seen at cycle %0d with no request outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        if ({o_quotient, o_remainder, o_div_by_zero} !== {mon_e.q, mon_e.r, mon_e.dz}) begin
          n_fail++;
          $display("FAIL result: got q=%0d r=%0d dz=%0d, expected q=%0d r=%0d dz=%0d",
                   o_quotient, o_remainder, o_div_by_zero, mon_e.q, mon_e.r, mon_e.dz);
        end
        n_checks++;
        if (cyc !== mon_e.due) begin
          n_fail++;
          $display("FAIL latency: done at cycle %0d, expected cycle %0d", cyc, mon_e.due);
        end
      end
    end
  end

  // Called just after a falling edge with the DUT idle; returns just after the
  // falling edge following the accepting rising edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    sb.push_back(model(a, b, cyc));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Counts busy cycles up to the done cycle and checks busy is low in it.
  task automatic count_busy(input int exp_cnt, input string name);
    int  cnt;
    bit  seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_done === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if (o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy_in_done: busy=%0b, expected 0", name, o_busy);
        end
        break;
      end
      if (o_busy === 1'b1) cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (!seen || cnt != exp_cnt) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d (done seen=%0b), expected %0d", name, cnt, seen, exp_cnt);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_checks++;
    if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL %s: busy=%0b done=%0b q=%0d r=%0d dz=%0b, expected all 0",
               name, o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(4'd11, 4'd3);
    count_busy(WIDTH, "basic");
    wait_idle();
  endtask

  task automatic test_multiplier_inverse();
    logic [WIDTH-1:0] pairs [4][2];
    pairs = '{'{4'd6, 4'd3}, '{4'd15, 4'd1}, '{4'd2, 4'd3}, '{4'd15, 4'd15}};
    for (int i = 0; i < 4; i++) begin
      issue(pairs[i][0], pairs[i][1]);
      wait_idle();
    end
  endtask

  task automatic test_div_zero();
    issue(4'd9, 4'd0);
    count_busy(ZCHK ? 0 : WIDTH, "div_zero");
    wait_idle();
    // A valid division afterwards must clear the error flag.
    issue(4'd7, 4'd2);
    wait_idle();
  endtask

  task automatic test_ignored_start();
    int d0;
    d0 = n_done;
    issue(4'd13, 4'd2);
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = 4'd7;
    i_divisor  = 4'd7;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL ignored_start_done_count: got %0d done pulses, expected 1", n_done - d0);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    i_start    = 1'b1;
    i_dividend = 4'd14;
    i_divisor  = 4'd4;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_abort");
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_done != d0) begin
      n_fail++;
      $display("FAIL reset_abort_done: got %0d done pulses after reset, expected 0", n_done - d0);
    end
    issue(4'd14, 4'd4);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit seen;
    seen       = 1'b0;
    i_start    = 1'b1;
    i_dividend = 4'd9;
    i_divisor  = 4'd2;
    sb.push_back(model(4'd9, 4'd2, cyc));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL back_to_back_first_done: done seen=0, expected 1");
    end
    i_dividend = 4'd8;
    i_divisor  = 4'd3;
    sb.push_back(model(4'd8, 4'd3, cyc));
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_multiplier_inverse();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
